// File: rtl/display_arbiter.sv
// Round-robin arbiter that shares the four-digit display between three requesters,
// latching the winner's BCD digits and holding them for HOLD_CYCLES clock cycles.
module display_arbiter #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  ack,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [1:0]  active,
    output logic        blank
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        digits_q, digits_d;
    logic [1:0]         active_q, active_d;
    logic [2:0]         ack_q, ack_d;
    logic [1:0]         last_q, last_d;
    logic               blank_q, blank_d;

    logic [1:0]         cand [3];
    logic [1:0]         winner;
    logic               found;
    logic [15:0]        sel_data;
    logic               do_grant;

    // Search order starts just after the most recently granted requester.
    always_comb begin
        cand[0] = 2'd0;
        cand[1] = 2'd1;
        cand[2] = 2'd2;
        case (last_q)
            2'd0: begin
                cand[0] = 2'd1;
                cand[1] = 2'd2;
                cand[2] = 2'd0;
            end
            2'd1: begin
                cand[0] = 2'd2;
                cand[1] = 2'd0;
                cand[2] = 2'd1;
            end
            default: ;
        endcase

        found  = 1'b0;
        winner = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[cand[k]]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end

        case (winner)
            2'd0:    sel_data = data0;
            2'd1:    sel_data = data1;
            default: sel_data = data2;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        active_d = active_q;
        ack_d    = 3'b000;
        last_d   = last_q;
        blank_d  = blank_q;
        do_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (|req) begin
                    do_grant = 1'b1;
                end else begin
                    state_d  = IDLE;
                    active_d = 2'b11;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            state_d  = SHOW;
            digits_d = sel_data;
            active_d = winner;
            ack_d    = 3'b001 << winner;
            last_d   = winner;
            blank_d  = 1'b0;
            cnt_d    = HOLD_M1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digits_q <= 16'h0000;
            active_q <= 2'b11;
            ack_q    <= 3'b000;
            last_q   <= 2'd2;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            last_q   <= last_d;
            blank_q  <= blank_d;
        end
    end

    assign ack    = ack_q;
    assign digit1 = digits_q[15:12];
    assign digit2 = digits_q[11:8];
    assign digit3 = digits_q[7:4];
    assign digit4 = digits_q[3:0];
    assign active = active_q;
    assign blank  = blank_q;

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the four-digit seven-segment display between three requesters (e.g. PC, accumulator, ALU result debug views of the 8-bit processor). Uses round-robin arbitration with a guaranteed minimum on-screen hold time. It latches the winning requester's four BCD digits and drives them to the `in1`..`in4` inputs of the downstream `time_multiplexer`, which performs the anode/cathode scan.

## Interface
- `HOLD_CYCLES`, default 100_000_000: minimum number of clock cycles a granted value stays displayed before re-arbitration. Legal range ≥1. Benches use 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  level request per requester; requester holds it high until it sees its `ack` bit.
- `data0`  in  16  requester 0 digits; [15:12] is the leftmost digit, [3:0] the rightmost.
- `data1`  in  16  requester 1 digits; same packing as `data0`.
- `data2`  in  16  requester 2 digits; same packing as `data0`.
- `ack`  out  3  one-hot, one-cycle pulse in the cycle after the corresponding request is granted and latched.
- `digit1`  out  4  leftmost digit, connected to `time_multiplexer` `in1`.
- `digit2`  out  4  connected to `in2`.
- `digit3`  out  4  connected to `in3`.
- `digit4`  out  4  rightmost digit, connected to `in4`.
- `active`  out  2  index of the source currently holding the display; 2'b11 = none (idle).
- `blank`  out  1  high until the first grant after reset; top level gates the anodes with it.

## Operation
- All outputs are registered.
- Reset values:
  - `digit1`..`digit4` = 0.
  - `ack` = 0.
  - `active` = 2'b11.
  - `blank` = 1.
  - State = IDLE.
  - Hold counter = 0.
  - Round-robin pointer `last` = 2, so requester 0 has first priority.
- Hold counter width is `$clog2(HOLD_CYCLES)`, minimum 1.
- States: IDLE and SHOW.
- IDLE:
  - If `req` = 0, remain in IDLE.
  - If any `req` bit is set, perform a grant and go to SHOW.
- SHOW:
  - While counter ≠ 0: decrement. `req` is ignored, and digits and `active` are frozen.
  - When counter = 0 and any `req` bit is set: perform a grant (which may re-grant the same source) and stay in SHOW.
  - When counter = 0 and `req` = 0: go to IDLE. Set `active` = 2'b11. Digits retain their last value; `blank` stays 0.
- Grant, performed on one edge:
  - Winner = first requester with `req` set, searching `last+1`, `last+2`, `last+3` (mod 3).
  - Latch the winner's data: [15:12]→`digit1`, [11:8]→`digit2`, [7:4]→`digit3`, [3:0]→`digit4`.
  - Set `active` = winner, `ack[winner]` = 1, `last` = winner, `blank` = 0.
  - Load counter with `HOLD_CYCLES-1`.
- `ack` clears on the next edge unconditionally.
- Digit values 10–15 pass through unchanged; decoding belongs to `time_multiplexer`.
- Data changes on a non-granted or already-granted source do not affect the displayed digits until that source is granted again.

## Timing
- Grant latency: `req` sampled high at edge t (IDLE, or SHOW with counter = 0) → `ack`, digits, and `active` valid after edge t.
- Hold time: each granted value is displayed for exactly `HOLD_CYCLES` cycles before the next grant can replace it.
- Continuous requests: grants are spaced exactly `HOLD_CYCLES` cycles apart.
- Requester holding `req` after its `ack`: it competes again at the next expiry, and round-robin puts it last.
- `HOLD_CYCLES` = 1: the counter is always 0, so the arbiter can grant on every cycle.
- Simultaneous requests: resolved only by the round-robin order. There is no fixed priority except immediately after reset.
- Reset during SHOW: `reset` overrides everything at the next edge. A pending grant is dropped (no `ack`), and all outputs return to reset values.

## Test plan
- Reset check: assert `reset` 2 cycles → `digit1..4` = 0, `active` = 3, `blank` = 1, `ack` = 0.
- Single request, `HOLD_CYCLES` = 4:
  - Stimulus: `req` = 3'b010, `data1` = 16'h2548; drop `req` on `ack`.
  - Next cycle: `ack` = 3'b010 for exactly 1 cycle; digits 2,5,4,8; `active` = 1; `blank` = 0.
  - 4 cycles after the grant: `active` = 3, digits still 2548.
- Round-robin, `HOLD_CYCLES` = 4:
  - Stimulus: `req` = 3'b111 held; `data0`/`data1`/`data2` = 16'h1111/16'h2222/16'h3333.
  - Response: `active` sequence 0,1,2,0, each held exactly 4 cycles; `ack` pulses every 4 cycles.
- Mid-hold request: while source 0 is shown, raise `req[2]` one cycle after its grant → no change during hold; grant 2 at counter expiry with `ack` = 3'b100.
- Reset mid-SHOW: during SHOW with `req` = 3'b011 pending, pulse `reset` → next cycle all reset values; no `ack` pulse.
- Minimum hold: `HOLD_CYCLES` = 1, `req` = 3'b101 held → `active` alternates 0,2,0,2 on consecutive cycles.
